// File: rtl/mima_alu_seq.sv
// Sequential MIMA ALU: valid/ready operand intake, registered result/flags held until taken,
// and an iterative one-bit-per-cycle rotate-right.
module mima_alu_seq #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_RAR = 3'd5;
  localparam logic [2:0] OP_EQL = 3'd6;
  localparam logic [2:0] OP_SUB = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     w_result_nxt;
  logic                 r_carry;
  logic                 w_carry_nxt;
  logic                 r_zero;
  logic                 w_zero_nxt;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [SHAMT_W-1:0]   w_cnt_nxt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_alu;
  logic                 w_alu_carry;
  logic [SHAMT_W-1:0]   w_amt;
  logic [WIDTH-1:0]     w_rot1;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};
  assign w_amt  = b[SHAMT_W-1:0];
  // r_result doubles as the rotate working register while in ROT
  assign w_rot1 = {r_result[0], r_result[WIDTH-1:1]};

  // Single-cycle operations; RAR here only covers the zero-amount case
  always_comb begin
    w_alu       = '0;
    w_alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu       = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
      end
      OP_AND: w_alu = a & b;
      OP_OR:  w_alu = a | b;
      OP_XOR: w_alu = a ^ b;
      OP_NOT: w_alu = ~a;
      OP_RAR: w_alu = a;
      OP_EQL: w_alu = (a == b) ? '1 : '0;
      OP_SUB: begin
        w_alu       = w_diff[WIDTH-1:0];
        w_alu_carry = ~w_diff[WIDTH];
      end
      default: w_alu = '0;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_carry_nxt  = r_carry;
    w_zero_nxt   = r_zero;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if ((op == OP_RAR) && (w_amt != '0)) begin
            w_state_nxt  = S_ROT;
            w_cnt_nxt    = w_amt;
            w_result_nxt = a;
            w_carry_nxt  = 1'b0;
            w_zero_nxt   = 1'b0;
          end else begin
            w_state_nxt  = S_DONE;
            w_result_nxt = w_alu;
            w_carry_nxt  = w_alu_carry;
            w_zero_nxt   = (w_alu == '0);
          end
        end
      end
      S_ROT: begin
        w_result_nxt = w_rot1;
        w_cnt_nxt    = r_cnt - SHAMT_W'(1);
        if (r_cnt == SHAMT_W'(1)) begin
          w_state_nxt = S_DONE;
          w_zero_nxt  = (w_rot1 == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_result <= w_result_nxt;
      r_carry  <= w_carry_nxt;
      r_zero   <= w_zero_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;

endmodule

// File: tb/tb_mima_alu_seq.sv
// Directed vector table, handshake/reset corner sequences and a randomised scoreboard run
// for mima_alu_seq at WIDTH=24.
module tb_mima_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] result;
  logic        carry;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] res;
    logic        c;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  mima_alu_seq #(.WIDTH(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: {carry, zero, result}
  function automatic logic [25:0] model(input logic [2:0] o, input logic [23:0] x, input logic [23:0] y);
    logic [24:0] s;
    logic [23:0] r;
    logic        c;
    int          k;
    c = 1'b0;
    r = '0;
    case (o)
      3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[23:0]; c = s[24]; end
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: r = ~x;
      3'd5: begin
        k = int'(y[4:0]) % 24;
        r = (k == 0) ? x : ((x >> k) | (x << (24 - k)));
      end
      3'd6: r = (x == y) ? 24'hFFFFFF : 24'h000000;
      default: begin r = x - y; c = (x >= y); end
    endcase
    return {c, (r == 24'h0), r};
  endfunction

  task automatic run_op(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
    chk({nm, "_res"}, 32'(result), 32'(v.res));
    chk({nm, "_cz"}, 32'({carry, zero}), 32'({v.c, v.z}));
    chk({nm, "_busy"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [25:0] q[$];
    logic [25:0] exp_v;
    int          pushed;
    int          popped;
    bit          seen;

    vecs[0]  = '{3'd0, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b1, 1};
    vecs[1]  = '{3'd5, 24'h000001, 24'h000003, 24'h200000, 1'b0, 1'b0, 4};
    vecs[2]  = '{3'd5, 24'hABCDEF, 24'h000000, 24'hABCDEF, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd5, 24'h123456, 24'h000018, 24'h123456, 1'b0, 1'b0, 25};
    vecs[4]  = '{3'd6, 24'h123456, 24'h123456, 24'hFFFFFF, 1'b0, 1'b0, 1};
    vecs[5]  = '{3'd6, 24'h123456, 24'h123457, 24'h000000, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'd7, 24'h000005, 24'h000007, 24'hFFFFFE, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd7, 24'h000007, 24'h000005, 24'h000002, 1'b1, 1'b0, 1};
    vecs[8]  = '{3'd7, 24'h000005, 24'h000005, 24'h000000, 1'b1, 1'b1, 1};
    vecs[9]  = '{3'd1, 24'hF0F0F0, 24'hFF00FF, 24'hF000F0, 1'b0, 1'b0, 1};
    vecs[10] = '{3'd2, 24'hF0F0F0, 24'h0F0F00, 24'hFFFFF0, 1'b0, 1'b0, 1};
    vecs[11] = '{3'd3, 24'hAAAAAA, 24'hFFFFFF, 24'h555555, 1'b0, 1'b0, 1};
    vecs[12] = '{3'd4, 24'h0F0F0F, 24'h000123, 24'hF0F0F0, 1'b0, 1'b0, 1};
    vecs[13] = '{3'd0, 24'h123456, 24'h111111, 24'h234567, 1'b0, 1'b0, 1};
    vecs[14] = '{3'd5, 24'h000003, 24'h000001, 24'h800001, 1'b0, 1'b0, 2};
    vecs[15] = '{3'd5, 24'h000010, 24'h00001F, 24'h200000, 1'b0, 1'b0, 32};
    vecs[16] = '{3'd4, 24'hFFFFFF, 24'h000000, 24'h000000, 1'b0, 1'b1, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ovalid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_cz", 32'({carry, zero}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_irdy", 32'(in_ready), 32'd1);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: new request while a result is pending is ignored
    @(negedge clk);
    in_valid = 1'b1; op = 3'd3; a = 24'h0F0F0F; b = 24'h00FF00;
    @(negedge clk);
    op = 3'd0; a = 24'h000001; b = 24'h000001;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ovalid", 32'(out_valid), 32'd1);
      chk("bp_irdy", 32'(in_ready), 32'd0);
      chk("bp_res", 32'(result), 32'h0FF00F);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ovalid", 32'(out_valid), 32'd0);
    chk("bp_idle_irdy", 32'(in_ready), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_nocap", 32'(out_valid), 32'd0);

    // Reset in the middle of a long rotate
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; a = 24'hABCDEF; b = 24'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ovalid", 32'(out_valid), 32'd0);
    chk("mid_rst_res", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_discard", 32'(seen), 32'd0);
    run_op('{3'd0, 24'h000002, 24'h000003, 24'h000005, 1'b0, 1'b0, 1}, "post_rst_add");

    // Random traffic against the reference model
    pushed = 0;
    popped = 0;
    for (int cyc = 0; popped < 10000 && cyc < 80000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(3) != 0) && (pushed < 10000);
      op        = 3'($urandom_range(7));
      a         = 24'($urandom);
      b         = ($urandom_range(3) == 0) ? a : 24'($urandom);
      out_ready = ($urandom_range(3) != 0);
      if (in_valid && in_ready) begin
        q.push_back(model(op, a, b));
        pushed++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_dup: result %h delivered with no outstanding op", result);
        end else begin
          exp_v = q.pop_front();
          chk("rnd", 32'({carry, zero, result}), 32'(exp_v));
        end
        popped++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_count", 32'(popped), 32'd10000);
    chk("rnd_lost", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
